// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush controller with data-memory wait FSM and stall counter
module pipeline_hazard_ctrl #(
    parameter int DM_TIMEOUT = 200,
    parameter int TO_W       = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_id_i,
    input  logic [4:0]       Rs2_id_i,
    input  logic             Rs1_used_id_i,
    input  logic             Rs2_used_id_i,
    input  logic [4:0]       Rd_id_ex_i,
    input  logic             MemRead_id_ex_i,
    input  logic             jump_taken_ex_i,
    input  logic             mem_access_ex_mem_i,
    input  logic             dm_ack_i,
    output logic             dm_req_o,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_bubble_o,
    output logic             dm_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              dm_timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              load_use;
    logic              flow;

    assign load_use = MemRead_id_ex_i && (Rd_id_ex_i != 5'd0) &&
                      ((Rs1_used_id_i && (Rs1_id_i == Rd_id_ex_i)) ||
                       (Rs2_used_id_i && (Rs2_id_i == Rd_id_ex_i)));

    always_comb begin
        state_d         = state_q;
        to_cnt_d        = to_cnt_q;
        flow            = 1'b0;
        dm_req_o        = 1'b0;
        pc_en_o         = 1'b0;
        if_id_en_o      = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_en_o      = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_en_o     = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_access_ex_mem_i && !dm_ack_i) begin
                        dm_req_o        = 1'b1;
                        mem_wb_bubble_o = 1'b1;
                        state_d         = MEM_WAIT;
                        to_cnt_d        = '0;
                    end else begin
                        dm_req_o = mem_access_ex_mem_i;
                        flow     = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dm_req_o = 1'b1;
                    if (dm_ack_i) begin
                        flow    = 1'b1;
                        state_d = RUN;
                    end else begin
                        mem_wb_bubble_o = 1'b1;
                        if (to_cnt_q == TO_W'(DM_TIMEOUT - 1))
                            state_d = ERROR;
                        else
                            to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                default: mem_wb_bubble_o = 1'b1;
            endcase
        end
        // Redirect wins over load-use: the ID instruction is wrong-path anyway.
        if (flow) begin
            pc_en_o     = 1'b1;
            if_id_en_o  = 1'b1;
            id_ex_en_o  = 1'b1;
            ex_mem_en_o = 1'b1;
            if (jump_taken_ex_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            to_cnt_q     <= '0;
            dm_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            if (state_q == ERROR)
                dm_timeout_q <= 1'b1;
            if ((state_q != ERROR) && !pc_en_o && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign dm_timeout_o = dm_timeout_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule
